// File: rtl/fft_helpers_butterfly_scheduler.sv
// Issue sequencer for an iterative in-place radix-2 FFT that shares one butterfly unit.
// Walks every stage, issues operand addresses and twiddles, then drains write-backs.
module fft_helpers_butterfly_scheduler #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int SIZE_FFT   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_val,
    output logic                          start_rdy,
    input  logic [BIT_WIDTH*SIZE_FFT-1:0] sine_wave_in,
    output logic                          bf_val,
    input  logic                          bf_rdy,
    output logic [$clog2(SIZE_FFT)-1:0]   bf_addr_a,
    output logic [$clog2(SIZE_FFT)-1:0]   bf_addr_b,
    output logic [$clog2(SIZE_FFT)-1:0]   bf_stage,
    output logic [BIT_WIDTH-1:0]          bf_twiddle_real,
    output logic [BIT_WIDTH-1:0]          bf_twiddle_imag,
    input  logic                          wb_ack,
    output logic                          busy,
    output logic                          done
);
    localparam int AW = $clog2(SIZE_FFT);
    localparam logic [AW-1:0] HALF    = AW'(SIZE_FFT / 2);
    localparam logic [AW-1:0] LAST_B  = AW'(SIZE_FFT / 2 - 1);
    localparam logic [AW-1:0] LAST_S  = AW'(AW - 1);
    localparam logic [AW-1:0] QUARTER = AW'(SIZE_FFT / 4);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The fractional point only travels with the data; reject nonsensical sizes early.
    if (DECIMAL_PT < 0 || DECIMAL_PT >= BIT_WIDTH || SIZE_FFT < 4 ||
        (SIZE_FFT & (SIZE_FFT - 1)) != 0) begin : g_bad_params
        $error("fft_helpers_butterfly_scheduler: illegal parameter set");
    end

    function automatic logic [BIT_WIDTH-1:0] neg_wrap(input logic signed [BIT_WIDTH-1:0] x);
        return -x;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] stage_q, stage_d;
    logic [AW-1:0] b_q, b_d;
    logic [AW-1:0] ack_q, ack_d;

    logic [BIT_WIDTH-1:0] sine_tbl [SIZE_FFT];
    for (genvar k = 0; k < SIZE_FFT; k++) begin : g_tbl
        assign sine_tbl[k] = sine_wave_in[k*BIT_WIDTH +: BIT_WIDTH];
    end

    logic [AW-1:0] span;
    logic [AW-1:0] m;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] tw_idx;
    logic [AW-1:0] re_idx;

    // Address/twiddle decode depends only on registered s and b, so it holds while stalled.
    always_comb begin
        span   = AW'(1) << stage_q;
        m      = b_q & (span - AW'(1));
        addr_a = ((b_q >> stage_q) << (stage_q + AW'(1))) + m;
        tw_idx = m << (LAST_S - stage_q);
        re_idx = tw_idx + QUARTER;
    end

    assign bf_addr_a       = addr_a;
    assign bf_addr_b       = addr_a + span;
    assign bf_stage        = stage_q;
    assign bf_twiddle_real = sine_tbl[re_idx];
    assign bf_twiddle_imag = neg_wrap(sine_tbl[tw_idx]);

    assign start_rdy = (state_q == ST_IDLE);
    assign bf_val    = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

    logic          ack_inc;
    logic [AW-1:0] ack_next;

    always_comb begin
        ack_inc  = wb_ack && busy && (ack_q != HALF);
        ack_next = ack_q + {{(AW-1){1'b0}}, ack_inc};

        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        ack_d   = ack_q;

        case (state_q)
            ST_IDLE: begin
                if (start_val) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    b_d     = '0;
                    ack_d   = '0;
                end
            end
            ST_ISSUE: begin
                ack_d = ack_next;
                if (bf_rdy) begin
                    if (b_q == LAST_B) begin
                        state_d = ST_DRAIN;
                    end else begin
                        b_d = b_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                ack_d = ack_next;
                if (ack_next == HALF) begin
                    ack_d = '0;
                    b_d   = '0;
                    if (stage_q == LAST_S) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + AW'(1);
                    end
                end
            end
            default: begin
                // Leave IDLE looking exactly like the reset state.
                state_d = ST_IDLE;
                stage_d = '0;
                b_d     = '0;
                ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            b_q     <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_fft_helpers_butterfly_scheduler.sv
// Directed bench for the butterfly scheduler: N=8 and N=16 instances on one clock.
module tb_fft_helpers_butterfly_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // N = 8 instance
    logic         start_val, start_rdy, bf_val, bf_rdy, wb_ack, busy, done;
    logic [255:0] sine8;
    logic [2:0]   a8, b8, st8;
    logic [31:0]  re8, im8;

    // N = 16 instance
    logic         start16, rdy_out16, val16, rdy16, ack16, busy16, done16;
    logic [511:0] sine16;
    logic [3:0]   a16, b16, st16;
    logic [31:0]  re16, im16;

    logic [31:0] tbl8 [8] = '{32'h00000000, 32'h0000B505, 32'h00010000, 32'h0000B505,
                              32'h00000000, 32'hFFFF4AFB, 32'hFFFF0000, 32'hFFFF4AFB};
    for (genvar k = 0; k < 8; k++) begin : g_t8
        assign sine8[k*32 +: 32] = tbl8[k];
    end
    for (genvar k = 0; k < 16; k++) begin : g_t16
        assign sine16[k*32 +: 32] = 32'h10000000 + 32'(k) * 32'h0101;
    end

    // Hand-derived issue order for N=8: operand pair and twiddle index per issue.
    int ea   [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int eb   [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int eidx [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    fft_helpers_butterfly_scheduler #(.BIT_WIDTH(32), .DECIMAL_PT(16), .SIZE_FFT(8)) dut8 (
        .clk(clk), .reset(reset), .start_val(start_val), .start_rdy(start_rdy),
        .sine_wave_in(sine8), .bf_val(bf_val), .bf_rdy(bf_rdy), .bf_addr_a(a8),
        .bf_addr_b(b8), .bf_stage(st8), .bf_twiddle_real(re8), .bf_twiddle_imag(im8),
        .wb_ack(wb_ack), .busy(busy), .done(done)
    );

    fft_helpers_butterfly_scheduler #(.BIT_WIDTH(32), .DECIMAL_PT(16), .SIZE_FFT(16)) dut16 (
        .clk(clk), .reset(reset), .start_val(start16), .start_rdy(rdy_out16),
        .sine_wave_in(sine16), .bf_val(val16), .bf_rdy(rdy16), .bf_addr_a(a16),
        .bf_addr_b(b16), .bf_stage(st16), .bf_twiddle_real(re16), .bf_twiddle_imag(im16),
        .wb_ack(ack16), .busy(busy16), .done(done16)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_start_rdy"}, 32'(start_rdy), 32'd1);
        chk({tag, "_bf_val"}, 32'(bf_val), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic chk_issue(input int i);
        chk("issue_addr_a", 32'(a8), 32'(ea[i]));
        chk("issue_addr_b", 32'(b8), 32'(eb[i]));
        chk("issue_stage", 32'(st8), 32'(i / 4));
        chk("issue_tw_real", re8, tbl8[(eidx[i] + 2) % 8]);
        chk("issue_tw_imag", im8, 32'd0 - tbl8[eidx[i]]);
    endtask

    // Full N=8 run with acks one cycle after each accepted issue.
    task automatic run8(input bit rnd);
        int n_iss, n_done, n_ack, cycles, ack_last, done_cyc;
        bit pend;
        n_iss = 0; n_done = 0; n_ack = 0; cycles = 0; ack_last = -10; done_cyc = -10; pend = 0;
        @(negedge clk); start_val = 1'b1; bf_rdy = 1'b1;
        @(negedge clk); start_val = 1'b0;
        chk("start_to_issue", 32'(bf_val), 32'd1);
        while (cycles < 400 && !(n_done > 0 && start_rdy)) begin
            if (done) begin
                n_done++;
                done_cyc = cycles;
                chk("done_after_last_ack", 32'(cycles), 32'(ack_last + 1));
                chk("done_start_rdy_low", 32'(start_rdy), 32'd0);
            end
            bf_rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (bf_val) begin
                if (n_iss < 12) chk_issue(n_iss);
                else chk("extra_issue", 32'(n_iss), 32'd11);
                if (n_iss == 5) begin
                    chk("s1b1_real", re8, 32'h00000000);
                    chk("s1b1_imag", im8, 32'hFFFF0000);
                end
                if (n_iss == 11) begin
                    chk("s2b3_real", re8, 32'hFFFF4AFB);
                    chk("s2b3_imag", im8, 32'hFFFF4AFB);
                end
                if (bf_rdy) n_iss++;
            end
            wb_ack = pend;
            if (pend) begin
                n_ack++;
                if (n_ack == 12) ack_last = cycles;
            end
            pend = bf_val && bf_rdy;
            @(negedge clk);
            cycles++;
        end
        wb_ack = 1'b0;
        bf_rdy = 1'b1;
        chk("issue_count", 32'(n_iss), 32'd12);
        chk("done_count", 32'(n_done), 32'd1);
        chk("rdy_after_done", 32'(cycles), 32'(done_cyc + 1));
        chk_idle("post_run");
    endtask

    initial begin
        int n16, dn16;
        bit pend16;
        reset = 1'b1; start_val = 1'b0; bf_rdy = 1'b0; wb_ack = 1'b0;
        start16 = 1'b0; rdy16 = 1'b0; ack16 = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_addr_a", 32'(a8), 32'd0);
        chk("reset_addr_b", 32'(b8), 32'd1);
        chk("reset_stage", 32'(st8), 32'd0);
        chk("reset_tw_real", re8, 32'h00010000);
        chk("reset_tw_imag", im8, 32'h00000000);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        run8(1'b0);
        run8(1'b1);

        // Withheld stage-0 acks, then reset in the middle of stage 1.
        @(negedge clk); start_val = 1'b1; bf_rdy = 1'b1; wb_ack = 1'b0;
        @(negedge clk); start_val = 1'b0;
        repeat (4) @(negedge clk);
        repeat (20) begin
            chk("drain_no_issue", 32'(bf_val), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            chk("ack_wait_no_issue", 32'(bf_val), 32'd0);
            wb_ack = 1'b1;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        chk("stage1_first_issue", 32'(bf_val), 32'd1);
        chk("stage1_first_stage", 32'(st8), 32'd1);
        chk("stage1_first_b", 32'(b8), 32'd2);
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            chk_idle("reset_stays_idle");
            @(negedge clk);
        end

        // Six acks while stalled in stage 0, with start_val held high throughout.
        start_val = 1'b1; bf_rdy = 1'b0;
        @(negedge clk);
        repeat (6) begin
            wb_ack = 1'b1;
            chk("stall_val", 32'(bf_val), 32'd1);
            chk("stall_addr_a", 32'(a8), 32'd0);
            @(negedge clk);
        end
        wb_ack = 1'b0; bf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sat_issue_addr_a", 32'(a8), 32'(ea[i]));
            chk("start_held_ignored", 32'(start_rdy), 32'd0);
            @(negedge clk);
        end
        chk("sat_drain", 32'(bf_val), 32'd0);
        @(negedge clk);
        chk("sat_next_stage_val", 32'(bf_val), 32'd1);
        chk("sat_next_stage", 32'(st8), 32'd1);
        chk("sat_next_addr_b", 32'(b8), 32'd2);
        repeat (4) @(negedge clk);
        repeat (5) begin
            chk("sat_no_spill_val", 32'(bf_val), 32'd0);
            chk("sat_no_spill_busy", 32'(busy), 32'd1);
            chk("sat_stage_once", 32'(st8), 32'd1);
            @(negedge clk);
        end
        start_val = 1'b0;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk_idle("after_sat");

        // N=16 run.
        start16 = 1'b1; rdy16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        n16 = 0; dn16 = 0; pend16 = 1'b0;
        for (int c = 0; c < 300 && !(dn16 > 0 && rdy_out16); c++) begin
            if (done16) dn16++;
            if (val16) begin
                if (n16 == 31) begin
                    chk("n16_last_stage", 32'(st16), 32'd3);
                    chk("n16_last_a", 32'(a16), 32'd7);
                    chk("n16_last_b", 32'(b16), 32'd15);
                    chk("n16_last_real", re16, 32'h10000B0B);
                    chk("n16_last_imag", im16, 32'hEFFFF8F9);
                end
                n16++;
            end
            ack16 = pend16;
            pend16 = val16;
            @(negedge clk);
        end
        ack16 = 1'b0;
        chk("n16_issue_count", 32'(n16), 32'd32);
        chk("n16_done_count", 32'(dn16), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
